// File: rtl/seq_counter_pkg.sv
// Shared definitions for the shift-register sequence counters.
//   MODE_JOHNSON / MODE_RING : counter flavour selectors
//   MAX_W                    : widest register the helper functions handle
//   is_legal(q, width, mode) : 1 when the low 'width' bits of q form a reachable state
//   reset_val(width, mode)   : reset/recovery value, zero-extended to MAX_W
package seq_counter_pkg;

    localparam int MODE_JOHNSON = 0;
    localparam int MODE_RING    = 1;
    localparam int MAX_W        = 32;

    // Johnson states are exactly the words with at most one 0/1 transition
    // between adjacent bits (1..10..0, 0..01..1, all-0, all-1).
    // Ring states have exactly one bit set.
    function automatic logic is_legal(input logic [MAX_W-1:0] q,
                                      input int               width,
                                      input int               mode);
        int ones;
        int trans;
        ones  = 0;
        trans = 0;
        for (int i = 0; i < MAX_W; i++) begin
            if (i < width && q[i]) ones++;
        end
        for (int i = 1; i < MAX_W; i++) begin
            if (i < width && (q[i] != q[i-1])) trans++;
        end
        if (mode == MODE_RING) return (ones == 1);
        return (trans <= 1);
    endfunction

    function automatic logic [MAX_W-1:0] reset_val(input int width,
                                                   input int mode);
        logic [MAX_W-1:0] r;
        r = '0;
        if (mode == MODE_RING) r[width-1] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/twisted_ring_decode.sv
// Combinational decode of a Johnson or ring counter word.
//   count : counter register (WIDTH)
//   index : phase number 0..P-1, 0 for an illegal word (IDX_W)
//   legal : 1 when count is a reachable state
module twisted_ring_decode
    import seq_counter_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int MODE  = MODE_JOHNSON,
    parameter int IDX_W = $clog2(2*WIDTH)
) (
    input  logic [WIDTH-1:0] count,
    output logic [IDX_W-1:0] index,
    output logic             legal
);

    logic [IDX_W:0]   ones;
    logic [IDX_W:0]   back_half;
    logic [IDX_W-1:0] pos;

    assign legal = is_legal(MAX_W'(count), WIDTH, MODE);

    always_comb begin
        ones = '0;
        pos  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            ones = ones + {{IDX_W{1'b0}}, count[i]};
            if (count[i]) pos = IDX_W'(WIDTH - 1 - i);
        end
        // Second half of the Johnson cycle (0111..0001): W + zeros = 2W - ones.
        back_half = (IDX_W+1)'(2*WIDTH) - ones;

        index = '0;
        if (legal) begin
            if (MODE == MODE_RING) begin
                index = pos;
            end else if (count == '0 || count[WIDTH-1]) begin
                index = ones[IDX_W-1:0];
            end else begin
                index = back_half[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/twisted_ring_counter.sv
// Johnson / one-hot ring sequence counter with enable, direction, parallel
// load, illegal-state recovery, phase index and wrap pulse.
//   clk      : clock, rising edge
//   rst      : synchronous reset, active low
//   en       : step enable
//   dir      : 1 = up, 0 = down
//   load     : parallel load strobe (beats en/dir)
//   load_val : value to load; illegal values load the reset value instead
//   count    : counter register
//   index    : phase number, combinational from count
//   wrap     : one-cycle pulse when a step crosses the P-1 <-> 0 boundary
//   err      : one-cycle flag for an illegal load or a recovered illegal state
module twisted_ring_counter
    import seq_counter_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int MODE  = MODE_JOHNSON,
    parameter int IDX_W = $clog2(2*WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic [IDX_W-1:0] index,
    output logic             wrap,
    output logic             err
);

    localparam int               P       = (MODE == MODE_RING) ? WIDTH : 2*WIDTH;
    localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(reset_val(WIDTH, MODE));

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] step_val;
    logic             step_wrap;
    logic             cur_legal;
    logic             load_legal;
    logic             fb_up;
    logic             fb_dn;

    assign count = count_q;

    twisted_ring_decode #(
        .WIDTH (WIDTH),
        .MODE  (MODE),
        .IDX_W (IDX_W)
    ) u_decode (
        .count (count_q),
        .index (index),
        .legal (cur_legal)
    );

    assign load_legal = is_legal(MAX_W'(load_val), WIDTH, MODE);

    // Johnson inverts the bit fed back around the ring; the one-hot ring does not.
    always_comb begin
        fb_up     = (MODE == MODE_RING) ? count_q[0]       : ~count_q[0];
        fb_dn     = (MODE == MODE_RING) ? count_q[WIDTH-1] : ~count_q[WIDTH-1];
        step_val  = count_q;
        step_wrap = 1'b0;
        if (dir) begin
            step_val  = {fb_up, count_q[WIDTH-1:1]};
            step_wrap = (index == IDX_W'(P-1));
        end else begin
            step_val  = {count_q[WIDTH-2:0], fb_dn};
            step_wrap = (index == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= RST_VAL;
            wrap    <= 1'b0;
            err     <= 1'b0;
        end else if (load) begin
            count_q <= load_legal ? load_val : RST_VAL;
            err     <= ~load_legal;
            wrap    <= 1'b0;
        end else if (!cur_legal) begin
            count_q <= RST_VAL;
            err     <= 1'b1;
            wrap    <= 1'b0;
        end else if (en) begin
            count_q <= step_val;
            wrap    <= step_wrap;
            err     <= 1'b0;
        end else begin
            wrap <= 1'b0;
            err  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_twisted_ring_counter.sv
module tb_twisted_ring_counter;

    typedef struct {
        int         mode;
        logic [8:0] v;      // {count, index, wrap, err}
        string      tag;
    } exp_t;

    logic       clk;
    logic       rst_j, en_j, dir_j, load_j;
    logic [3:0] lv_j, count_j;
    logic [2:0] index_j;
    logic       wrap_j, err_j;
    logic       rst_r, en_r, dir_r, load_r;
    logic [3:0] lv_r, count_r;
    logic [2:0] index_r;
    logic       wrap_r, err_r;

    int   checks   = 0;
    int   failures = 0;
    exp_t sbq[$];

    logic [3:0] m_cnt  [2];
    logic       m_wrap [2];
    logic       m_err  [2];

    twisted_ring_counter #(.WIDTH(4), .MODE(0)) dut_j (
        .clk(clk), .rst(rst_j), .en(en_j), .dir(dir_j), .load(load_j),
        .load_val(lv_j), .count(count_j), .index(index_j), .wrap(wrap_j), .err(err_j)
    );

    twisted_ring_counter #(.WIDTH(4), .MODE(1)) dut_r (
        .clk(clk), .rst(rst_r), .en(en_r), .dir(dir_r), .load(load_r),
        .load_val(lv_r), .count(count_r), .index(index_r), .wrap(wrap_r), .err(err_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference sequences listed as phase tables.
    function automatic logic [3:0] seqv(input int mode, input int i);
        if (mode == 0) begin
            case (i)
                0: return 4'b0000;  1: return 4'b1000;
                2: return 4'b1100;  3: return 4'b1110;
                4: return 4'b1111;  5: return 4'b0111;
                6: return 4'b0011;  default: return 4'b0001;
            endcase
        end
        case (i)
            0: return 4'b1000;  1: return 4'b0100;
            2: return 4'b0010;  default: return 4'b0001;
        endcase
    endfunction

    function automatic int find(input int mode, input logic [3:0] v);
        int p;
        p = (mode == 0) ? 8 : 4;
        for (int i = 0; i < p; i++) if (seqv(mode, i) == v) return i;
        return -1;
    endfunction

    function automatic void model_step(input int mode, input logic r, input logic e,
                                       input logic d, input logic l, input logic [3:0] lv);
        int         p;
        int         i;
        logic [3:0] rv;
        p  = (mode == 0) ? 8 : 4;
        rv = (mode == 0) ? 4'b0000 : 4'b1000;
        if (!r) begin
            m_cnt[mode] = rv; m_wrap[mode] = 1'b0; m_err[mode] = 1'b0;
        end else if (l) begin
            if (find(mode, lv) >= 0) begin
                m_cnt[mode] = lv; m_err[mode] = 1'b0;
            end else begin
                m_cnt[mode] = rv; m_err[mode] = 1'b1;
            end
            m_wrap[mode] = 1'b0;
        end else if (find(mode, m_cnt[mode]) < 0) begin
            m_cnt[mode] = rv; m_err[mode] = 1'b1; m_wrap[mode] = 1'b0;
        end else if (e) begin
            i = find(mode, m_cnt[mode]);
            if (d) begin
                m_wrap[mode] = (i == p-1);
                m_cnt[mode]  = seqv(mode, (i + 1) % p);
            end else begin
                m_wrap[mode] = (i == 0);
                m_cnt[mode]  = seqv(mode, (i + p - 1) % p);
            end
            m_err[mode] = 1'b0;
        end else begin
            m_wrap[mode] = 1'b0; m_err[mode] = 1'b0;
        end
    endfunction

    function automatic logic [2:0] exp_index(input int mode);
        int i;
        i = find(mode, m_cnt[mode]);
        return (i < 0) ? 3'd0 : 3'(i);
    endfunction

    function automatic logic [8:0] observe(input int mode);
        if (mode == 0) return {count_j, index_j, wrap_j, err_j};
        return {count_r, index_r, wrap_r, err_r};
    endfunction

    // Drive one cycle of stimulus, push the model's expectation, advance past the edge.
    task automatic drive(input int mode, input logic r, input logic e, input logic d,
                         input logic l, input logic [3:0] lv, input string tag);
        exp_t x;
        if (mode == 0) begin
            rst_j = r; en_j = e; dir_j = d; load_j = l; lv_j = lv;
        end else begin
            rst_r = r; en_r = e; dir_r = d; load_r = l; lv_r = lv;
        end
        model_step(mode, r, e, d, l, lv);
        x.mode = mode;
        x.v    = {m_cnt[mode], exp_index(mode), m_wrap[mode], m_err[mode]};
        x.tag  = tag;
        sbq.push_back(x);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t x;
        for (int i = 0; i < 2; i++) begin
            drive(0, 1'b0, 1'b1, 1'b1, 1'b1, 4'b0101, "reset");
            x = sbq.pop_front();
            checks++;
            if (observe(x.mode) !== x.v) begin
                failures++;
                $display("FAIL %s edge %0d: got %b want %b", x.tag, i, observe(x.mode), x.v);
            end
        end
        checks++;
        if ({count_j, index_j, wrap_j, err_j} !== 9'b0000_000_0_0) begin
            failures++;
            $display("FAIL reset_const: got %b want 000000000", {count_j, index_j, wrap_j, err_j});
        end
    endtask

    task automatic test_johnson_up();
        exp_t x;
        for (int i = 0; i < 8; i++) begin
            drive(0, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, "johnson_up");
            x = sbq.pop_front();
            checks++;
            if (observe(x.mode) !== x.v) begin
                failures++;
                $display("FAIL %s step %0d: got %b want %b", x.tag, i, observe(x.mode), x.v);
            end
        end
        checks++;
        if (count_j !== 4'b0000 || wrap_j !== 1'b1) begin
            failures++;
            $display("FAIL johnson_up_wrap: got count=%b wrap=%b want 0000/1", count_j, wrap_j);
        end
    endtask

    task automatic test_dir_reversal();
        exp_t x;
        for (int i = 0; i < 2; i++) begin
            drive(0, 1'b1, 1'b1, (i == 1), 1'b0, 4'b0000, "dir_reversal");
            x = sbq.pop_front();
            checks++;
            if (observe(x.mode) !== x.v) begin
                failures++;
                $display("FAIL %s step %0d: got %b want %b", x.tag, i, observe(x.mode), x.v);
            end
            if (i == 0) begin
                checks++;
                if (count_j !== 4'b0001 || index_j !== 3'd7 || wrap_j !== 1'b1) begin
                    failures++;
                    $display("FAIL down_wrap_const: got %b/%0d/%b want 0001/7/1", count_j, index_j, wrap_j);
                end
            end
        end
    endtask

    task automatic test_hold_load();
        exp_t x;
        // two up steps to 1100, three holds, then load with en high
        for (int i = 0; i < 6; i++) begin
            drive(0, 1'b1, (i < 2 || i == 5), 1'b1, (i == 5), 4'b0011, "hold_load");
            x = sbq.pop_front();
            checks++;
            if (observe(x.mode) !== x.v) begin
                failures++;
                $display("FAIL %s step %0d: got %b want %b", x.tag, i, observe(x.mode), x.v);
            end
        end
        checks++;
        if (count_j !== 4'b0011 || index_j !== 3'd6 || err_j !== 1'b0) begin
            failures++;
            $display("FAIL load_const: got %b/%0d/%b want 0011/6/0", count_j, index_j, err_j);
        end
    endtask

    task automatic test_illegal();
        exp_t x;
        for (int i = 0; i < 2; i++) begin
            drive(0, 1'b1, 1'b0, 1'b1, (i == 0), 4'b0101, "illegal_load");
            x = sbq.pop_front();
            checks++;
            if (observe(x.mode) !== x.v) begin
                failures++;
                $display("FAIL %s step %0d: got %b want %b", x.tag, i, observe(x.mode), x.v);
            end
        end
        force dut_j.count_q = 4'b1010;
        #1;
        release dut_j.count_q;
        m_cnt[0] = 4'b1010;
        checks++;
        if (count_j !== 4'b1010 || index_j !== 3'd0) begin
            failures++;
            $display("FAIL seu_index: got %b/%0d want 1010/0", count_j, index_j);
        end
        for (int i = 0; i < 2; i++) begin
            drive(0, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, "illegal_state");
            x = sbq.pop_front();
            checks++;
            if (observe(x.mode) !== x.v) begin
                failures++;
                $display("FAIL %s step %0d: got %b want %b", x.tag, i, observe(x.mode), x.v);
            end
        end
    endtask

    task automatic test_ring();
        exp_t x;
        // 2 resets, 4 up (wrap on last), 2 up to 0010, then reset mid-sequence, 1 down
        for (int i = 0; i < 10; i++) begin
            drive(1, !(i < 2 || i == 8), 1'b1, (i != 9), 1'b0, 4'b0000, "ring");
            x = sbq.pop_front();
            checks++;
            if (observe(x.mode) !== x.v) begin
                failures++;
                $display("FAIL %s step %0d: got %b want %b", x.tag, i, observe(x.mode), x.v);
            end
            if (i == 5) begin
                checks++;
                if (count_r !== 4'b1000 || wrap_r !== 1'b1) begin
                    failures++;
                    $display("FAIL ring_wrap_const: got %b/%b want 1000/1", count_r, wrap_r);
                end
            end
            if (i == 8) begin
                checks++;
                if (count_r !== 4'b1000 || index_r !== 3'd0) begin
                    failures++;
                    $display("FAIL ring_reset_const: got %b/%0d want 1000/0", count_r, index_r);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t x;
        for (int i = 0; i < 60; i++) begin
            int m;
            m = (i < 40) ? 0 : 1;
            drive(m, ($urandom_range(0, 19) != 0), $urandom_range(0, 1), $urandom_range(0, 1),
                  ($urandom_range(0, 5) == 0), 4'($urandom_range(0, 15)), "back_to_back");
            x = sbq.pop_front();
            checks++;
            if (observe(x.mode) !== x.v) begin
                failures++;
                $display("FAIL %s step %0d: got %b want %b", x.tag, i, observe(x.mode), x.v);
            end
        end
    endtask

    initial begin
        rst_j = 1'b0; en_j = 1'b0; dir_j = 1'b1; load_j = 1'b0; lv_j = 4'b0000;
        rst_r = 1'b0; en_r = 1'b0; dir_r = 1'b1; load_r = 1'b0; lv_r = 4'b0000;
        m_cnt[0] = 4'b0000; m_wrap[0] = 1'b0; m_err[0] = 1'b0;
        m_cnt[1] = 4'b1000; m_wrap[1] = 1'b0; m_err[1] = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_johnson_up();
        test_dir_reversal();
        test_hold_load();
        test_illegal();
        test_ring();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
